// File: rtl/sc_stream_gen.sv
// sc_stream_gen
//   Stochastic-number generator stage. On an accepted start it latches a
//   binary probability, then for LEN cycles compares the incoming LFSR word
//   against it, emitting one unary stream bit per cycle (1 when rnd_Y < prob)
//   and counting the ones. ones_count is the decoded estimate of the run.
//
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   rnd_Y       in   WIDTH  random word from the LFSR, sampled every RUN cycle
//   prob        in   WIDTH  probability numerator (prob / 2^WIDTH), sampled on start
//   start       in   1      run request, accepted only while ready=1
//   ready       out  1      high in IDLE (decoded from the state register)
//   bit_valid   out  1      bit_out carries a stream bit this cycle
//   bit_out     out  1      registered stream bit (holds last value when idle)
//   done        out  1      one-cycle pulse: run complete, ones_count final
//   ones_count  out  CNT_W  ones in the current/last run (2^CNT_W > LEN)
module sc_stream_gen #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LEN   = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] rnd_Y,
  input  logic [WIDTH-1:0] prob,
  input  logic             start,
  output logic             ready,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             done,
  output logic [CNT_W-1:0] ones_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prob_q;
  logic [CNT_W-1:0] idx;
  logic             hit;

  // Strict unsigned less-than: prob_q = 0 can never produce a one.
  always_comb begin
    hit = (rnd_Y < prob_q);
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prob_q     <= '0;
      idx        <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      // Pulse-style outputs default low; only RUN/DONE raise them.
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            prob_q     <= prob;
            idx        <= '0;
            ones_count <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          bit_out    <= hit;
          bit_valid  <= 1'b1;
          ones_count <= ones_count + {{(CNT_W-1){1'b0}}, hit};
          idx        <= idx + {{(CNT_W-1){1'b0}}, 1'b1};
          if (idx == CNT_W'(LEN - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_gen.sv
module tb_sc_stream_gen;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned LEN   = 32;
  localparam int unsigned CNT_W = 6;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] rnd_Y;
  logic [WIDTH-1:0] prob;
  logic             start;
  logic             ready;
  logic             bit_valid;
  logic             bit_out;
  logic             done;
  logic [CNT_W-1:0] ones_count;

  sc_stream_gen #(
    .WIDTH(WIDTH),
    .LEN  (LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rnd_Y     (rnd_Y),
    .prob      (prob),
    .start     (start),
    .ready     (ready),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .done      (done),
    .ones_count(ones_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic exp_bits[$];
  int   exp_cnt[$];
  int   run_bits = 0;
  logic [4:0] lfsr = 5'h1f;

  function automatic void check_eq(input string tag, input logic [31:0] got,
                                   input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endfunction

  // Output monitor: pops the scoreboard on every stream bit and done pulse.
  always @(negedge clock) begin
    if (!reset) begin
      run_bits = 0;
    end else begin
      if (bit_valid) begin
        check_eq("busy_in_run", {31'd0, ready}, 32'd0);
        if (exp_bits.size() == 0) check_eq("unexpected_bit", 32'd1, 32'd0);
        else check_eq("bit_out", {31'd0, bit_out}, {31'd0, exp_bits.pop_front()});
        run_bits++;
      end
      if (done) begin
        check_eq("run_len", run_bits, LEN);
        check_eq("ready_at_done", {31'd0, ready}, 32'd1);
        run_bits = 0;
        if (exp_cnt.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
        else check_eq("ones_count", {26'd0, ones_count}, exp_cnt.pop_front());
      end
    end
  end

  // Drives one run from the IDLE wait onward. abort_at >= 0 drops reset
  // just before stream bit abort_at is driven; pulse_at >= 0 pulses start
  // with prob=0 mid-run.
  task automatic do_run(input logic [4:0] p, input logic [4:0] rc,
                        input bit use_lfsr, input bit hold, input bit b2b,
                        input int pulse_at, input int abort_at);
    int n = 0;
    int ones = 0;
    logic [4:0] r;
    logic e;
    while (!ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("ready_wait", {31'd0, ready}, 32'd1);
    if (b2b) check_eq("b2b_gap", n, 32'd2);
    start = 1'b1;
    prob  = p;
    @(posedge clock); #1;
    check_eq("cnt_clear", {26'd0, ones_count}, 32'd0);
    check_eq("not_ready", {31'd0, ready}, 32'd0);
    if (!hold) start = 1'b0;
    for (int i = 0; i < int'(LEN); i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
      end
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check_eq("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        check_eq("rst_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ones", {26'd0, ones_count}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        exp_bits.delete();
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        return;
      end
      if (use_lfsr) begin
        r    = lfsr;
        lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      end else begin
        r = rc;
      end
      rnd_Y = r;
      e = (r < p);
      exp_bits.push_back(e);
      ones += int'(e);
      if (i == pulse_at) begin
        start = 1'b1;
        prob  = 5'd0;
      end else if (i == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    exp_cnt.push_back(ones);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    prob  = '0;
    rnd_Y = '0;
    #12;
    check_eq("reset_ready", {31'd0, ready}, 32'd1);
    check_eq("reset_valid", {31'd0, bit_valid}, 32'd0);
    check_eq("reset_bit", {31'd0, bit_out}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_ones", {26'd0, ones_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // prob=0: all zeros
    do_run(5'd0, 5'd7, 1'b0, 1'b0, 1'b0, -1, -1);
    // all ones, then strict less-than at equality
    do_run(5'd31, 5'd30, 1'b0, 1'b0, 1'b0, -1, -1);
    do_run(5'd31, 5'd31, 1'b0, 1'b0, 1'b0, -1, -1);
    // LFSR-driven, prob=16
    do_run(5'd16, 5'd0, 1'b1, 1'b0, 1'b0, -1, -1);
    // start + prob change mid-run ignored
    do_run(5'd16, 5'd0, 1'b1, 1'b0, 1'b0, 5, -1);
    // reset mid-run at stream bit 10
    do_run(5'd20, 5'd3, 1'b0, 1'b0, 1'b0, -1, 10);
    repeat (40) @(posedge clock);
    #1;
    check_eq("post_abort_ready", {31'd0, ready}, 32'd1);
    do_run(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, -1, -1);
    // start held high: three back-to-back runs
    do_run(5'd12, 5'd0, 1'b1, 1'b1, 1'b0, -1, -1);
    do_run(5'd25, 5'd0, 1'b1, 1'b1, 1'b1, -1, -1);
    do_run(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, -1, -1);

    for (int k = 0; k < 100 && (exp_bits.size() != 0 || exp_cnt.size() != 0); k++)
      @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check_eq("drain_bits", exp_bits.size(), 32'd0);
    check_eq("drain_done", exp_cnt.size(), 32'd0);
    check_eq("final_ready", {31'd0, ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
